// File: rtl/axi_burst_master_pkg.sv
// Shared types and constants for the AXI4 burst master: FSM state encoding and AXI field codes.
package axi_burst_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } axi_burst_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI beat size code: log2 of bytes per beat.
  function automatic logic [2:0] axi_size_of(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: one client block request becomes one read or write burst,
// with beats streamed to/from the client and a done/err pulse at the end.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_BEATS  = 16,
  localparam int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [DATA_WIDTH-1:0] cl_wdata,
  input  logic [STRB_W-1:0]     cl_wstrb,
  input  logic                  cl_wvalid,
  output logic                  cl_wready,
  output logic [DATA_WIDTH-1:0] cl_rdata,
  output logic                  cl_rvalid,
  input  logic                  cl_rready,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [STRB_W-1:0]     axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [ID_WIDTH-1:0]   axi_bid,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  localparam logic [2:0] AXSIZE = axi_size_of(DATA_WIDTH);

  axi_burst_state_t      state_q;
  logic [LEN_W:0]        cnt_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;

  logic at_last;
  logic w_hs;
  logic r_hs;
  logic unused_ids;

  // Only one ID is ever issued, so returned IDs carry no information.
  assign unused_ids = ^{axi_bid, axi_rid};

  assign at_last = (cnt_q == {1'b0, len_q});
  assign w_hs    = axi_wvalid & axi_wready;
  assign r_hs    = axi_rvalid & axi_rready;

  assign req_ready   = (state_q == IDLE);

  assign axi_awid    = ID_WIDTH'(AXI_ID);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = 8'(len_q);
  assign axi_awsize  = AXSIZE;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awvalid = (state_q == AW);

  assign axi_wdata   = cl_wdata;
  assign axi_wstrb   = cl_wstrb;
  assign axi_wvalid  = (state_q == W) & cl_wvalid;
  assign axi_wlast   = (state_q == W) & at_last;
  assign cl_wready   = (state_q == W) & axi_wready;

  assign axi_bready  = (state_q == B);

  assign axi_arid    = ID_WIDTH'(AXI_ID);
  assign axi_araddr  = addr_q;
  assign axi_arlen   = 8'(len_q);
  assign axi_arsize  = AXSIZE;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arvalid = (state_q == AR);

  assign axi_rready  = (state_q == R) & cl_rready;
  assign cl_rvalid   = (state_q == R) & axi_rvalid;
  assign cl_rdata    = axi_rdata;

  assign done        = (state_q == DONE);
  assign err         = (state_q == DONE) & err_q;

  // Request registers hold the burst parameters; they need no reset.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req_valid) begin
      addr_q <= req_addr;
      len_q  <= req_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (req_valid) state_q <= req_write ? AW : AR;
        end
        AW: if (axi_awready) state_q <= W;
        W: begin
          if (w_hs) begin
            cnt_q <= cnt_q + 1'b1;
            if (at_last) state_q <= B;
          end
        end
        B: begin
          if (axi_bvalid) begin
            err_q   <= err_q | (axi_bresp != AXI_RESP_OKAY);
            state_q <= DONE;
          end
        end
        AR: if (axi_arready) state_q <= R;
        R: begin
          if (r_hs) begin
            // Saturate so an over-long slave burst cannot wrap back to a valid count.
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if ((axi_rresp != AXI_RESP_OKAY) || (axi_rlast != at_last)) err_q <= 1'b1;
            if (axi_rlast) state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: bench acts as client and AXI slave, beats checked via scoreboard.
module tb_axi_burst_master;
  localparam int AW_ = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW_-1:0] req_addr;
  logic [3:0]    req_len;
  logic [DW-1:0] cl_wdata;
  logic [3:0]    cl_wstrb;
  logic          cl_wvalid, cl_wready;
  logic [DW-1:0] cl_rdata;
  logic          cl_rvalid, cl_rready;
  logic          done, err;
  logic [IW-1:0] axi_awid, axi_arid, axi_bid, axi_rid;
  logic [AW_-1:0] axi_awaddr, axi_araddr;
  logic [7:0]    axi_awlen, axi_arlen;
  logic [2:0]    axi_awsize, axi_arsize;
  logic [1:0]    axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic          axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic [3:0]    axi_wstrb;
  logic          axi_wlast, axi_wvalid, axi_wready;
  logic          axi_bvalid, axi_bready;
  logic          axi_rlast, axi_rvalid, axi_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .cl_wdata(cl_wdata), .cl_wstrb(cl_wstrb), .cl_wvalid(cl_wvalid), .cl_wready(cl_wready),
    .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid), .cl_rready(cl_rready),
    .done(done), .err(err),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rpat(input logic [31:0] addr, input int k);
    return addr * 3 + 32'(k) * 32'h0101_0101 + 32'h5A;
  endfunction

  function automatic logic [31:0] wpat(input logic [31:0] addr, input int k);
    return addr ^ (32'h1111_1111 * 32'(k + 1));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_valids"}, 64'({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int rlast_at,
                         input bit bad_resp, input bit rnd);
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int  k = 0;
    bit  fin = 0;
    bit  pending = 0;
    bit  exp_err = (rlast_at != len) || bad_resp;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = addr; req_len = 4'(len);
    #1 check("rd_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 0; axi_arready = 1;
    #1;
    check("rd_arvalid", 64'(axi_arvalid), 64'd1);
    check("rd_araddr", 64'(axi_araddr), 64'(addr));
    check("rd_arlen", 64'(axi_arlen), 64'(len));
    check("rd_arsize_burst", 64'({axi_arsize, axi_arburst}), 64'({3'd2, 2'b01}));
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      axi_arready = 0;
      if (!pending) begin
        axi_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        axi_rdata  = rpat(addr, k);
        axi_rlast  = (k == rlast_at);
        axi_rresp  = (bad_resp && k == 1) ? 2'b10 : 2'b00;
        if (axi_rvalid) exp_q.push_back(rpat(addr, k));
      end
      cl_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (axi_rvalid && cl_rready) begin
        check("rd_cl_rvalid", 64'(cl_rvalid), 64'd1);
        check("rd_axi_rready", 64'(axi_rready), 64'd1);
        e = exp_q.pop_front();
        check($sformatf("rd_data_beat%0d", k), 64'(cl_rdata), 64'(e));
        if (axi_rlast) fin = 1;
        k++;
        pending = 0;
      end else begin
        pending = axi_rvalid;
      end
    end
    check("rd_complete", 64'(fin), 64'd1);
    check("rd_sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0; cl_rready = 0;
    #1;
    check("rd_done", 64'(done), 64'd1);
    check("rd_err", 64'(err), 64'(exp_err));
    @(negedge clk);
    #1 check_idle("rd_after");
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int aw_delay,
                          input logic [1:0] bresp, input logic [3:0] strb, input bit rnd,
                          input int abort_k);
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int  k = 0;
    bit  fin = 0;
    bit  pending = 0;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = addr; req_len = 4'(len);
    #1 check("wr_req_ready", 64'(req_ready), 64'd1);
    for (int d = 0; d <= aw_delay; d++) begin
      @(negedge clk);
      req_valid = 0;
      axi_awready = (d == aw_delay);
      #1;
      check("wr_awvalid", 64'(axi_awvalid), 64'd1);
      check("wr_awaddr", 64'(axi_awaddr), 64'(addr));
      check("wr_awlen", 64'(axi_awlen), 64'(len));
      check("wr_no_early_w", 64'(axi_wvalid), 64'd0);
    end
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      axi_awready = 0;
      if (k == abort_k) begin
        rst_n = 0; cl_wvalid = 1; cl_wdata = wpat(addr, k); axi_wready = 1;
        @(negedge clk);
        rst_n = 1; cl_wvalid = 0; axi_wready = 0;
        #1 check_idle("abort");
        return;
      end
      if (!pending) begin
        cl_wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        cl_wdata  = wpat(addr, k);
        cl_wstrb  = strb;
        if (cl_wvalid) exp_q.push_back({27'd0, (k == len), strb, wpat(addr, k)});
      end
      axi_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("wr_cl_wready", 64'(cl_wready), 64'(axi_wready));
      if (cl_wvalid && axi_wready) begin
        check("wr_wvalid", 64'(axi_wvalid), 64'd1);
        e = exp_q.pop_front();
        check($sformatf("wr_beat%0d", k), {27'd0, axi_wlast, axi_wstrb, axi_wdata}, e);
        if (k == len) fin = 1;
        k++;
        pending = 0;
      end else begin
        pending = cl_wvalid;
      end
    end
    check("wr_complete", 64'(fin), 64'd1);
    check("wr_sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    cl_wvalid = 0; axi_wready = 0; axi_bvalid = 1; axi_bresp = bresp;
    #1 check("wr_bready", 64'(axi_bready), 64'd1);
    @(negedge clk);
    axi_bvalid = 0; axi_bresp = 0;
    #1;
    check("wr_done", 64'(done), 64'd1);
    check("wr_err", 64'(err), 64'(bresp != 2'b00));
    @(negedge clk);
    #1 check_idle("wr_after");
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    cl_wdata = 0; cl_wstrb = 0; cl_wvalid = 0; cl_rready = 0;
    axi_awready = 0; axi_wready = 0; axi_bid = 0; axi_bresp = 0; axi_bvalid = 0;
    axi_arready = 0; axi_rid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0; axi_rvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_err", 64'(err), 64'd0);
    rst_n = 1;

    do_read(32'h1000, 3, 3, 1'b0, 1'b0);
    do_write(32'h2000, 7, 3, 2'b00, 4'hF, 1'b0, -1);
    do_write(32'h3000, 0, 0, 2'b10, 4'h5, 1'b0, -1);
    do_read(32'h4000, 3, 1, 1'b0, 1'b0);
    do_read(32'h5000, 2, 2, 1'b1, 1'b0);
    do_read(32'h6000, 15, 15, 1'b0, 1'b1);
    do_write(32'h7000, 15, 1, 2'b00, 4'h9, 1'b1, -1);
    do_write(32'h8000, 7, 0, 2'b00, 4'hF, 1'b0, 1);
    do_read(32'h9000, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
